spi_ctrl: RTL and testbench

CPU-facing controller for the byte-level SPI master. It holds a small TX FIFO of bytes to send and an RX FIFO of bytes received, and runs a sequencer that hands one byte at a time to the master over the write/busy handshake. It also owns the slave-select, CPOL and CPHA configuration driven to the master and the bus. It sits between the CPU memory-mapped I/O decode and the SPI master.

---
 rtl/spi_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_spi_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl.sv
// spi_ctrl: CPU-facing controller for the byte-level SPI master.
// Holds a TX FIFO and an RX FIFO of bytes, plus a sequencer that hands one
// byte at a time to the master over the write/busy handshake. It also owns
// the CPOL/CPHA configuration and the slave-select register.
// Optional feature macro: SPI_CTRL_IRQ_EN adds the irq output and CTRL.irq_en.
module spi_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       m_write,
  input  logic       m_busy,
  output logic [7:0] m_din,
  input  logic [7:0] m_dout,
  output logic       cpol,
  output logic       cpha,
  output logic [7:0] ss_n
`ifdef SPI_CTRL_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [7:0]  r_txMem [DEPTH];
  logic [7:0]  r_rxMem [DEPTH];
  logic [AW:0] r_txWr, r_txRd, r_rxWr, r_rxRd;
  logic        r_txOvf, r_rxOvf;
  logic        r_cpol, r_cpha;
  logic [7:0]  r_ssel;

  logic        w_dataWr, w_statusWr, w_ctrlWr, w_sselWr, w_dataRd, w_anyRd;
  logic        w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
  logic        w_txPush, w_txPop, w_rxPop, w_rxPushReq, w_rxPush;
  logic        w_txOvfNext, w_rxOvfNext;
  logic [AW:0] w_txWrNext, w_txRdNext, w_rxWrNext, w_rxRdNext;
  logic [7:0]  w_statusNext;
  logic [7:0]  w_readData;
  logic        w_irqEnBit;
  logic [7:0]  w_txHead, w_rxHead;

  // Full when the wrap bits differ and the index bits match.
  function automatic logic ptrFull(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  // Register decode for the current CPU access.
  assign w_dataWr   = cs & we & (addr == 2'd0);
  assign w_statusWr = cs & we & (addr == 2'd1);
  assign w_ctrlWr   = cs & we & (addr == 2'd2);
  assign w_sselWr   = cs & we & (addr == 2'd3);
  assign w_dataRd   = cs & ~we & (addr == 2'd0);
  assign w_anyRd    = cs & ~we;

  assign w_txEmpty = (r_txWr == r_txRd);
  assign w_txFull  = ptrFull(r_txWr, r_txRd);
  assign w_rxEmpty = (r_rxWr == r_rxRd);
  assign w_rxFull  = ptrFull(r_rxWr, r_rxRd);

  assign w_txHead = r_txMem[r_txRd[AW-1:0]];
  assign w_rxHead = r_rxMem[r_rxRd[AW-1:0]];

  // A full TX drops the write; a CPU pop on a full RX frees the slot first.
  assign w_txPush    = w_dataWr & ~w_txFull;
  assign w_txPop     = (r_state == ST_ISSUE) & ~w_txEmpty;
  assign w_rxPop     = w_dataRd & ~w_rxEmpty;
  assign w_rxPushReq = (r_state == ST_CAPTURE);
  assign w_rxPush    = w_rxPushReq & (~w_rxFull | w_rxPop);

  assign w_txWrNext = r_txWr + {{AW{1'b0}}, w_txPush};
  assign w_txRdNext = r_txRd + {{AW{1'b0}}, w_txPop};
  assign w_rxWrNext = r_rxWr + {{AW{1'b0}}, w_rxPush};
  assign w_rxRdNext = r_rxRd + {{AW{1'b0}}, w_rxPop};

  // A new overflow event wins over a simultaneous software clear.
  assign w_txOvfNext = (w_dataWr & w_txFull) | (r_txOvf & ~(w_statusWr & wdata[5]));
  assign w_rxOvfNext = (w_rxPushReq & w_rxFull & ~w_rxPop) |
                       (r_rxOvf & ~(w_statusWr & wdata[6]));

  assign ss_n = ~r_ssel;
  assign cpol = r_cpol;
  assign cpha = r_cpha;

  // Sequencer next-state decode, also used so STATUS.active reflects the read edge.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:      if (!w_txEmpty) w_stateNext = ST_ISSUE;
      ST_ISSUE:     w_stateNext = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (m_busy) w_stateNext = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!m_busy) w_stateNext = ST_CAPTURE;
      ST_CAPTURE:   w_stateNext = ST_IDLE;
      default:      w_stateNext = ST_IDLE;
    endcase
  end

  // STATUS is built from post-edge values so it includes same-edge pushes and pops.
  always_comb begin
    w_statusNext    = 8'h00;
    w_statusNext[0] = ptrFull(w_txWrNext, w_txRdNext);
    w_statusNext[1] = (w_txWrNext == w_txRdNext);
    w_statusNext[2] = ptrFull(w_rxWrNext, w_rxRdNext);
    w_statusNext[3] = (w_rxWrNext == w_rxRdNext);
    w_statusNext[4] = (w_stateNext != ST_IDLE);
    w_statusNext[5] = w_txOvfNext;
    w_statusNext[6] = w_rxOvfNext;
  end

  // Read mux for the registered rdata path.
  always_comb begin
    w_readData = 8'h00;
    case (addr)
      2'd0:    w_readData = w_rxEmpty ? 8'h00 : w_rxHead;
      2'd1:    w_readData = w_statusNext;
      2'd2:    w_readData = {5'b00000, w_irqEnBit, r_cpha, r_cpol};
      default: w_readData = r_ssel;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr[AW-1:0]] <= wdata;
    if (w_rxPush) r_rxMem[r_rxWr[AW-1:0]] <= m_dout;
  end

  // FIFO pointers and sticky overflow flags; reset flushes both FIFOs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_txWr  <= '0;
      r_txRd  <= '0;
      r_rxWr  <= '0;
      r_rxRd  <= '0;
      r_txOvf <= 1'b0;
      r_rxOvf <= 1'b0;
    end else begin
      r_txWr  <= w_txWrNext;
      r_txRd  <= w_txRdNext;
      r_rxWr  <= w_rxWrNext;
      r_rxRd  <= w_rxRdNext;
      r_txOvf <= w_txOvfNext;
      r_rxOvf <= w_rxOvfNext;
    end
  end

  // Sequencer with registered m_write/m_din; m_din latches the TX head on entry to ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      m_write <= 1'b0;
      m_din   <= 8'h00;
    end else begin
      r_state <= w_stateNext;
      m_write <= (w_stateNext == ST_ISSUE);
      if (r_state == ST_IDLE && !w_txEmpty) m_din <= w_txHead;
    end
  end

  // Registered read data, held until the next read access.
  always_ff @(posedge clk) begin
    if (!reset) rdata <= 8'h00;
    else if (w_anyRd) rdata <= w_readData;
  end

  // Configuration registers: clock mode and software-controlled slave select.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_ssel <= 8'h00;
    end else begin
      if (w_ctrlWr) begin
        r_cpol <= wdata[0];
        r_cpha <= wdata[1];
      end
      if (w_sselWr) r_ssel <= wdata;
    end
  end

`ifdef SPI_CTRL_IRQ_EN
  logic r_irqEn;

  assign w_irqEnBit = r_irqEn;

  // Interrupt enable plus registered interrupt; drops one cycle after its cause clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irqEn <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (w_ctrlWr) r_irqEn <= wdata[2];
      irq <= r_irqEn & (~w_rxEmpty | r_txOvf | r_rxOvf);
    end
  end
`else
  assign w_irqEnBit = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl with a behavioural SPI master model that
// echoes each byte inverted after a programmable busy time.
module tb_spi_ctrl;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_SSEL   = 2'd3;

`ifdef SPI_CTRL_IRQ_EN
  localparam logic [7:0] CTRL_ALL = 8'h07;
`else
  localparam logic [7:0] CTRL_ALL = 8'h03;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       m_write;
  logic       m_busy = 1'b0;
  logic [7:0] m_din;
  logic [7:0] m_dout = 8'h00;
  logic       cpol, cpha;
  logic [7:0] ss_n;
`ifdef SPI_CTRL_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;
  int issueCount = 0;
  logic [7:0] expIssue[$];
  logic [7:0] expRx[$];
  logic [7:0] expByte;

  int   busyLen = 4;
  bit   holdBusy = 1'b0;
  int   slaveCnt = 0;
  logic [7:0] slaveByte = 8'h00;

  spi_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .m_write(m_write), .m_busy(m_busy), .m_din(m_din),
    .m_dout(m_dout), .cpol(cpol), .cpha(cpha), .ss_n(ss_n)
`ifdef SPI_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Master model and issue scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && m_write === 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL m_write_in_reset: got 1 want 0");
    end
    if (m_write === 1'b1) begin
      issueCount++;
      checks++;
      if (expIssue.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_issue: got m_din=%02h want no m_write", m_din);
      end else begin
        expByte = expIssue.pop_front();
        if (m_din !== expByte) begin
          errors++;
          $display("[TB] FAIL issue_byte: got %02h want %02h", m_din, expByte);
        end
      end
      slaveByte = m_din;
      slaveCnt  = busyLen;
      m_busy    = 1'b1;
    end else if (m_busy && !holdBusy) begin
      if (slaveCnt <= 1) begin
        m_dout = slaveByte ^ 8'hFF;
        m_busy = 1'b0;
      end else begin
        slaveCnt--;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpuRead(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic pushByte(input logic [7:0] d);
    expIssue.push_back(d);
    expRx.push_back(d ^ 8'hFF);
    cpuWrite(A_DATA, d);
  endtask

  task automatic pollStatus(input logic [7:0] mask, input logic [7:0] val,
                            input int maxPolls, output bit ok, output logic [7:0] s);
    ok = 1'b0;
    s  = 8'h00;
    for (int i = 0; i < maxPolls; i++) begin
      cpuRead(A_STATUS, s);
      if ((s & mask) == val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitBusy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] s;
    reset = 1'b0;
    tick(); tick();
    checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL reset_ss_n: got %02h want ff", ss_n); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %02h want 00", rdata); end
    checks++; if (m_write !== 1'b0 || m_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_master: got %b/%02h want 0/00", m_write, m_din); end
    checks++; if (cpol !== 1'b0 || cpha !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode: got %b%b want 00", cpol, cpha); end
    reset = 1'b1;
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h0A) begin errors++; $display("[TB] FAIL reset_status: got %02h want 0a", s); end
  endtask

  task automatic test_config();
    logic [7:0] d;
    cpuWrite(A_CTRL, 8'hFF);
    checks++; if (cpol !== 1'b1 || cpha !== 1'b1) begin errors++; $display("[TB] FAIL ctrl_mode: got %b%b want 11", cpol, cpha); end
    cpuRead(A_CTRL, d);
    checks++; if (d !== CTRL_ALL) begin errors++; $display("[TB] FAIL ctrl_read: got %02h want %02h", d, CTRL_ALL); end
    cpuWrite(A_CTRL, 8'h00);
    checks++; if (cpol !== 1'b0 || cpha !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_clear: got %b%b want 00", cpol, cpha); end
    cpuWrite(A_SSEL, 8'h81);
    checks++; if (ss_n !== 8'h7E) begin errors++; $display("[TB] FAIL ssel_pins: got %02h want 7e", ss_n); end
    cpuRead(A_SSEL, d);
    checks++; if (d !== 8'h81) begin errors++; $display("[TB] FAIL ssel_read: got %02h want 81", d); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d, s;
    bit ok;
    int base = issueCount;
    busyLen = 16;
    pushByte(8'hA5);
    checks++; if (m_write !== 1'b0) begin errors++; $display("[TB] FAIL latency_n: got %b want 0", m_write); end
    tick();
    checks++; if (m_write !== 1'b1 || m_din !== 8'hA5) begin errors++; $display("[TB] FAIL latency_n1: got %b/%02h want 1/a5", m_write, m_din); end
    tick();
    checks++; if (m_write !== 1'b0) begin errors++; $display("[TB] FAIL pulse_width: got %b want 0", m_write); end
    pollStatus(8'h08, 8'h00, 60, ok, s);
    checks++; if (!ok || s !== 8'h02) begin errors++; $display("[TB] FAIL single_status: got %02h ok=%0d want 02", s, ok); end
    checks++; if (issueCount - base != 1) begin errors++; $display("[TB] FAIL single_issues: got %0d want 1", issueCount - base); end
    cpuRead(A_DATA, d);
    expByte = expRx.pop_front();
    checks++; if (d !== expByte) begin errors++; $display("[TB] FAIL single_data: got %02h want %02h", d, expByte); end
    cpuRead(A_DATA, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL empty_read: got %02h want 00", d); end
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h0A) begin errors++; $display("[TB] FAIL single_idle: got %02h want 0a", s); end
    busyLen = 4;
  endtask

  task automatic test_tx_overflow(output int base);
    logic [7:0] s;
    base = issueCount;
    holdBusy = 1'b1;
    for (int i = 1; i <= 5; i++) pushByte(8'(i * 8'h11));
    cpuWrite(A_DATA, 8'h66);
    tick(); tick(); tick();
    checks++; if (issueCount - base != 1) begin errors++; $display("[TB] FAIL txovf_issues: got %0d want 1", issueCount - base); end
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h39) begin errors++; $display("[TB] FAIL txovf_status: got %02h want 39", s); end
    cpuWrite(A_STATUS, 8'h20);
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h19) begin errors++; $display("[TB] FAIL txovf_clear: got %02h want 19", s); end
  endtask

  task automatic test_rx_overflow(input int base);
    logic [7:0] d, s;
    bit ok;
    holdBusy = 1'b0;
    pollStatus(8'h12, 8'h02, 200, ok, s);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rxovf_drain: got status %02h want idle and tx empty", s); end
    checks++; if (issueCount - base != 5) begin errors++; $display("[TB] FAIL rxovf_issues: got %0d want 5", issueCount - base); end
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h46) begin errors++; $display("[TB] FAIL rxovf_status: got %02h want 46", s); end
    for (int i = 0; i < 4; i++) begin
      cpuRead(A_DATA, d);
      expByte = expRx.pop_front();
      checks++; if (d !== expByte) begin errors++; $display("[TB] FAIL rxovf_data%0d: got %02h want %02h", i, d, expByte); end
    end
    void'(expRx.pop_front());
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h4A) begin errors++; $display("[TB] FAIL rxovf_empty: got %02h want 4a", s); end
    cpuWrite(A_STATUS, 8'h40);
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h0A) begin errors++; $display("[TB] FAIL rxovf_clear: got %02h want 0a", s); end
  endtask

  task automatic test_rx_simultaneous();
    logic [7:0] d, s;
    bit ok;
    busyLen = 3;
    for (int i = 1; i <= 4; i++) pushByte(8'(8'hC0 + i));
    pollStatus(8'hFF, 8'h06, 200, ok, s);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL simul_fill: got %02h want 06", s); end
    holdBusy = 1'b1;
    busyLen = 1;
    pushByte(8'hC5);
    waitBusy(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL simul_busy: got 0 want 1"); end
    tick(); tick(); tick();
    holdBusy = 1'b0;
    tick();
    cpuRead(A_DATA, d);
    expByte = expRx.pop_front();
    checks++; if (d !== expByte) begin errors++; $display("[TB] FAIL simul_oldest: got %02h want %02h", d, expByte); end
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h06) begin errors++; $display("[TB] FAIL simul_status: got %02h want 06", s); end
    for (int i = 0; i < 4; i++) begin
      cpuRead(A_DATA, d);
      expByte = expRx.pop_front();
      checks++; if (d !== expByte) begin errors++; $display("[TB] FAIL simul_data%0d: got %02h want %02h", i, d, expByte); end
    end
    busyLen = 4;
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] d, s;
    bit ok;
    int base;
    pushByte(8'h99);
    pollStatus(8'hFF, 8'h02, 100, ok, s);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_prep: got %02h want 02", s); end
    holdBusy = 1'b1;
    pushByte(8'h77);
    cpuWrite(A_DATA, 8'h88);
    waitBusy(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_busy: got 0 want 1"); end
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (m_write !== 1'b0) begin errors++; $display("[TB] FAIL midrst_write: got %b want 0", m_write); end
    reset = 1'b1;
    base = issueCount;
    expRx.delete();
    cpuRead(A_STATUS, s);
    checks++; if (s !== 8'h0A) begin errors++; $display("[TB] FAIL midrst_status: got %02h want 0a", s); end
    checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL midrst_ss_n: got %02h want ff", ss_n); end
    holdBusy = 1'b0;
    repeat (30) tick();
    checks++; if (issueCount != base) begin errors++; $display("[TB] FAIL midrst_quiet: got %0d issues want 0", issueCount - base); end
    pushByte(8'h3C);
    pollStatus(8'hFF, 8'h02, 100, ok, s);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_resume: got %02h want 02", s); end
    cpuRead(A_DATA, d);
    expByte = expRx.pop_front();
    checks++; if (d !== expByte) begin errors++; $display("[TB] FAIL midrst_data: got %02h want %02h", d, expByte); end
  endtask

  // Scenario sequence.
  initial begin
    int txBase;
    $display("[TB] starting spi_ctrl bench");
    test_reset();
    test_config();
    test_single_byte();
    test_tx_overflow(txBase);
    test_rx_overflow(txBase);
    test_rx_simultaneous();
    test_reset_mid_transfer();
    checks++;
    if (expIssue.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_issues: got %0d pending want 0", expIssue.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
